tournament_branch_predictor: RTL and testbench
==============================================

TOURNAMENT_BRANCH_PREDICTOR -- requirements
Module: tournament_branch_predictor

Interface
REQ-001 The block SHALL have parameter LHT_IDX_W, default 6, which is the log2 of the number of local counter entries.
REQ-002 The block SHALL have parameter GHR_W, default 8, which is the global history width and the log2 of the number of global (gshare) counter entries.
REQ-003 The block SHALL have parameter CHS_IDX_W, default 6, which is the log2 of the number of chooser counter entries.
REQ-004 The block SHALL have parameter CTR_W, default 2, which is the width of every saturating counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port pipeline_en, input, 1 bit: global stall; when 0, no state changes.
REQ-008 The block SHALL have ports pred_valid (input, 1) and pred_pc (input, 32): the fetch-stage branch lookup request.
REQ-009 The block SHALL have ports pred_taken (output, 1), pred_src (output, 1: 0 = local, 1 = global) and pred_ghr (output, GHR_W): the combinational lookup result and the history snapshot.
REQ-010 The block SHALL have ports res_valid (input, 1), res_pc (input, 32), res_taken (input, 1) and res_ghr (input, GHR_W): the resolved-branch update.
REQ-011 The block SHALL have ports res_local_pred, res_global_pred and res_pred_taken (input, 1 each): the component predictions and final prediction carried down from lookup time.
REQ-012 The block SHALL have port init_busy, output, 1 bit: high while tables are being initialised.

Function
REQ-013 Indexing SHALL be as follows: local idx = pc[LHT_IDX_W+1:2]; chooser idx = pc[CHS_IDX_W+1:2]; global idx = pc[GHR_W+1:2] XOR ghr.
REQ-014 Lookup SHALL be combinational from pred_pc and the current tables/GHR: pred_src = chooser MSB; pred_taken = MSB of the selected counter; pred_ghr = current speculative GHR.
REQ-015 Lookup SHALL reflect state before the current edge; a same-cycle resolve to the same index SHALL NOT be bypassed.
REQ-016 The FSM SHALL have states INIT and READY; reset SHALL enter INIT with walk index 0.
REQ-017 In INIT, one entry per cycle SHALL be written in every table (indices beyond a table's size SHALL be ignored) with WNT = 2^(CTR_W-1)-1; the walk SHALL cover 2^max(LHT_IDX_W,GHR_W,CHS_IDX_W) cycles, then the FSM SHALL go to READY.
REQ-018 INIT SHALL advance regardless of pipeline_en.
REQ-019 During INIT: init_busy=1, pred_taken=0, pred_src=0, and all pred/res inputs SHALL be ignored.
REQ-020 In READY with pipeline_en=1 and res_valid=1, the local counter at res_pc SHALL move +1 if res_taken and -1 otherwise, saturating at 0 and 2^CTR_W-1.
REQ-021 Under the same condition, the global counter at res_pc[GHR_W+1:2] XOR res_ghr SHALL update identically to the local counter.
REQ-022 Under the same condition, the chooser SHALL move +1 when only the global prediction was correct, -1 when only the local prediction was correct, and hold otherwise, saturating at the same bounds.
REQ-023 GHR speculative update: in READY with pipeline_en=1 and pred_valid=1, GHR SHALL become {GHR[GHR_W-2:0], pred_taken}.
REQ-024 GHR recovery: in READY with pipeline_en=1, res_valid=1 and res_taken != res_pred_taken, GHR SHALL become {res_ghr[GHR_W-2:0], res_taken}.
REQ-025 When recovery and the speculative update occur in the same cycle, recovery SHALL take priority and the speculative update SHALL be discarded.
REQ-026 GHR SHALL wrap by shifting; the oldest bit SHALL be dropped.
REQ-027 With pipeline_en=0 in READY: no table, GHR or FSM change.

Reset
REQ-028 Assertion of reset_n=0 SHALL asynchronously clear GHR to 0, set the FSM to INIT with walk index 0 and set init_busy=1, overriding any in-progress activity.
REQ-029 Assertion of reset_n=0 mid-INIT SHALL restart the walk from index 0.

Verification
REQ-030 Reset release, defaults -> init_busy=1 for exactly 256 cycles, pred_taken=0, pred_ghr=0x00; then init_busy=0 and lookup at any PC gives pred_taken=0, pred_src=0.
REQ-031 Two resolves at res_pc=0x40, taken=1, res_local_pred=0, res_global_pred=0 -> local[16] goes 01->10->11, chooser holds at 01; lookup at 0x40 gives pred_taken=1, pred_src=0.
REQ-032 Two resolves at res_pc=0x80, taken=1, res_local_pred=0, res_global_pred=1 -> chooser[32] goes 01->10->11; lookup at 0x80 gives pred_src=1.
REQ-033 GHR=0xAA, pred_valid=1 with pred_taken=0, same cycle res_valid=1, res_ghr=0x05, res_taken=1, res_pred_taken=0 -> next GHR=0x0B.
REQ-034 pipeline_en=0 with pred_valid=1, res_valid=1 for 5 cycles -> GHR and all counters unchanged.
REQ-035 reset_n pulsed low at INIT cycle 100 -> init_busy stays 1 and completes a full 256-cycle walk from index 0.

Source files
------------

// File: rtl/tournament_branch_predictor.sv
// -----------------------------------------------------------------------------
// tournament_branch_predictor
//
// Tournament (local / gshare) conditional branch direction predictor.
//
// Three tables of CTR_W-bit saturating counters:
//   - local table   : indexed by pc[LHT_IDX_W+1:2]
//   - global table  : gshare, indexed by pc[GHR_W+1:2] XOR ghr
//   - chooser table : indexed by pc[CHS_IDX_W+1:2]; MSB=1 selects global
//
// After reset a walk writes every table entry to weakly-not-taken, one index
// per cycle, over 2^max(LHT_IDX_W, GHR_W, CHS_IDX_W) cycles. Lookups and
// updates are ignored until the walk completes.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   reset_n          : asynchronous active-low reset
//   pipeline_en      : global stall; 0 freezes tables, GHR and FSM (READY only)
//   pred_valid       : fetch-stage lookup request (drives speculative GHR shift)
//   pred_pc          : lookup PC
//   pred_taken       : combinational predicted direction
//   pred_src         : 0 = local component chosen, 1 = global component chosen
//   pred_ghr         : speculative GHR snapshot seen by this lookup
//   res_valid        : resolved-branch update strobe
//   res_pc           : resolved branch PC
//   res_taken        : actual outcome
//   res_ghr          : GHR snapshot captured at lookup time for this branch
//   res_local_pred   : local component prediction made at lookup time
//   res_global_pred  : global component prediction made at lookup time
//   res_pred_taken   : final prediction made at lookup time
//   init_busy        : high while the initialisation walk is running
//   dbg_state_o      : current FSM state (0 = INIT, 1 = READY)
//
// Handshake: pred_valid and res_valid are single-cycle strobes qualified by
// pipeline_en; there is no back-pressure. A request is consumed on the rising
// edge where the strobe, pipeline_en and READY are all high, and is dropped
// otherwise.
// -----------------------------------------------------------------------------
module tournament_branch_predictor #(
    parameter int LHT_IDX_W = 6,
    parameter int GHR_W     = 8,
    parameter int CHS_IDX_W = 6,
    parameter int CTR_W     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pipeline_en,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    output logic             pred_src,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_taken,
    input  logic [GHR_W-1:0] res_ghr,
    input  logic             res_local_pred,
    input  logic             res_global_pred,
    input  logic             res_pred_taken,
    output logic             init_busy,
    output logic             dbg_state_o
);

    localparam int LHT_ENTRIES = 1 << LHT_IDX_W;
    localparam int GHT_ENTRIES = 1 << GHR_W;
    localparam int CHS_ENTRIES = 1 << CHS_IDX_W;

    // The walk must be wide enough to reach every entry of the largest table.
    localparam int WALK_W_LG = (LHT_IDX_W > GHR_W) ? LHT_IDX_W : GHR_W;
    localparam int WALK_W    = (WALK_W_LG > CHS_IDX_W) ? WALK_W_LG : CHS_IDX_W;

    localparam logic [WALK_W-1:0] WALK_LAST = '1;
    localparam logic [CTR_W-1:0]  CTR_MAX   = '1;
    localparam logic [CTR_W-1:0]  CTR_WNT   = CTR_W'((1 << (CTR_W - 1)) - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [WALK_W-1:0] walk_q,  walk_d;
    logic [GHR_W-1:0]  ghr_q,   ghr_d;

    logic [CTR_W-1:0]  lht_q [LHT_ENTRIES];
    logic [CTR_W-1:0]  ght_q [GHT_ENTRIES];
    logic [CTR_W-1:0]  chs_q [CHS_ENTRIES];

    // Saturating up/down step of one counter.
    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                  input logic             up);
        logic [CTR_W-1:0] nxt;
        nxt = ctr;
        if (up) begin
            if (ctr != CTR_MAX) begin
                nxt = ctr + CTR_W'(1);
            end
        end else begin
            if (ctr != '0) begin
                nxt = ctr - CTR_W'(1);
            end
        end
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // Lookup path (purely combinational from current state)
    // -------------------------------------------------------------------------
    logic [LHT_IDX_W-1:0] p_lidx;
    logic [GHR_W-1:0]     p_gidx;
    logic [CHS_IDX_W-1:0] p_cidx;
    logic [CTR_W-1:0]     p_lctr;
    logic [CTR_W-1:0]     p_gctr;
    logic [CTR_W-1:0]     p_cctr;

    assign p_lidx = pred_pc[LHT_IDX_W+1:2];
    assign p_gidx = pred_pc[GHR_W+1:2] ^ ghr_q;
    assign p_cidx = pred_pc[CHS_IDX_W+1:2];
    assign p_lctr = lht_q[p_lidx];
    assign p_gctr = ght_q[p_gidx];
    assign p_cctr = chs_q[p_cidx];

    // Tables hold stale contents during the walk, so the outputs are forced
    // to a local not-taken prediction until READY.
    always_comb begin
        pred_taken = 1'b0;
        pred_src   = 1'b0;
        if (state_q == ST_READY) begin
            pred_src   = p_cctr[CTR_W-1];
            pred_taken = p_cctr[CTR_W-1] ? p_gctr[CTR_W-1] : p_lctr[CTR_W-1];
        end
    end

    assign pred_ghr    = ghr_q;
    assign init_busy   = (state_q == ST_INIT);
    assign dbg_state_o = state_q;

    // -------------------------------------------------------------------------
    // Resolve path
    // -------------------------------------------------------------------------
    logic [LHT_IDX_W-1:0] r_lidx;
    logic [GHR_W-1:0]     r_gidx;
    logic [CHS_IDX_W-1:0] r_cidx;
    logic                 upd_en;
    logic                 res_fire;
    logic                 local_ok;
    logic                 global_ok;
    logic                 mispredict;

    // The global index uses the history captured at lookup time, not the
    // current speculative GHR, so the same counter that predicted is trained.
    assign r_lidx     = res_pc[LHT_IDX_W+1:2];
    assign r_gidx     = res_pc[GHR_W+1:2] ^ res_ghr;
    assign r_cidx     = res_pc[CHS_IDX_W+1:2];
    assign upd_en     = (state_q == ST_READY) && pipeline_en;
    assign res_fire   = upd_en && res_valid;
    assign local_ok   = (res_local_pred == res_taken);
    assign global_ok  = (res_global_pred == res_taken);
    assign mispredict = (res_taken != res_pred_taken);

    // -------------------------------------------------------------------------
    // Table write ports: one write per table per cycle, from either the
    // initialisation walk or a resolve.
    // -------------------------------------------------------------------------
    logic                 lht_we;
    logic [LHT_IDX_W-1:0] lht_widx;
    logic [CTR_W-1:0]     lht_wdata;
    logic                 ght_we;
    logic [GHR_W-1:0]     ght_widx;
    logic [CTR_W-1:0]     ght_wdata;
    logic                 chs_we;
    logic [CHS_IDX_W-1:0] chs_widx;
    logic [CTR_W-1:0]     chs_wdata;

    always_comb begin
        lht_we    = 1'b0;
        lht_widx  = r_lidx;
        lht_wdata = ctr_step(lht_q[r_lidx], res_taken);
        ght_we    = 1'b0;
        ght_widx  = r_gidx;
        ght_wdata = ctr_step(ght_q[r_gidx], res_taken);
        chs_we    = 1'b0;
        chs_widx  = r_cidx;
        // Chooser moves towards whichever component alone was right.
        chs_wdata = ctr_step(chs_q[r_cidx], global_ok);

        if (state_q == ST_INIT) begin
            // Smaller tables see walk indices past their end; those are skipped.
            lht_we    = (int'(walk_q) < LHT_ENTRIES);
            lht_widx  = walk_q[LHT_IDX_W-1:0];
            lht_wdata = CTR_WNT;
            ght_we    = (int'(walk_q) < GHT_ENTRIES);
            ght_widx  = walk_q[GHR_W-1:0];
            ght_wdata = CTR_WNT;
            chs_we    = (int'(walk_q) < CHS_ENTRIES);
            chs_widx  = walk_q[CHS_IDX_W-1:0];
            chs_wdata = CTR_WNT;
        end else if (res_fire) begin
            lht_we = 1'b1;
            ght_we = 1'b1;
            chs_we = (local_ok != global_ok);
        end
    end

    // Tables carry no reset; the walk establishes their contents.
    always_ff @(posedge clk) begin
        if (lht_we) begin
            lht_q[lht_widx] <= lht_wdata;
        end
        if (ght_we) begin
            ght_q[ght_widx] <= ght_wdata;
        end
        if (chs_we) begin
            chs_q[chs_widx] <= chs_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // FSM and GHR next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        ghr_d   = ghr_q;
        case (state_q)
            ST_INIT: begin
                // The walk is not gated by pipeline_en.
                walk_d = walk_q + WALK_W'(1);
                if (walk_q == WALK_LAST) begin
                    state_d = ST_READY;
                    walk_d  = '0;
                end
            end
            ST_READY: begin
                if (pipeline_en) begin
                    // A mispredict rebuilds history from the branch's own
                    // snapshot, discarding any younger speculative shift.
                    if (res_valid && mispredict) begin
                        ghr_d = {res_ghr[GHR_W-2:0], res_taken};
                    end else if (pred_valid) begin
                        ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                walk_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            walk_q  <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
            ghr_q   <= ghr_d;
        end
    end

    // Only the index fields of the PCs are meaningful.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, res_pc};

endmodule

// File: tb/tb_tournament_branch_predictor.sv
module tb_tournament_branch_predictor;

    localparam int GHR_W       = 8;
    localparam int LHT_N       = 64;
    localparam int GHT_N       = 256;
    localparam int CHS_N       = 64;
    localparam int WALK_CYCLES = 256;
    localparam int CMAX        = 3;
    localparam int WNT         = 1;
    localparam int THRESH      = 2;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             reset_n;
    logic             pipeline_en;
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic             pred_src;
    logic [GHR_W-1:0] pred_ghr;
    logic             res_valid;
    logic [31:0]      res_pc;
    logic             res_taken;
    logic [GHR_W-1:0] res_ghr;
    logic             res_local_pred;
    logic             res_global_pred;
    logic             res_pred_taken;
    logic             init_busy;
    logic             dbg_state_o;

    always #5 clk = ~clk;

    tournament_branch_predictor dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pipeline_en     (pipeline_en),
        .pred_valid      (pred_valid),
        .pred_pc         (pred_pc),
        .pred_taken      (pred_taken),
        .pred_src        (pred_src),
        .pred_ghr        (pred_ghr),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_ghr         (res_ghr),
        .res_local_pred  (res_local_pred),
        .res_global_pred (res_global_pred),
        .res_pred_taken  (res_pred_taken),
        .init_busy       (init_busy),
        .dbg_state_o     (dbg_state_o)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------
    // Reference model: plain integer counters, busy countdown
    // ------------------------------------------------------------------
    int m_loc [LHT_N];
    int m_glb [GHT_N];
    int m_chs [CHS_N];
    int m_ghr;
    int m_busy;

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > CMAX) ? CMAX : v);
    endfunction

    function automatic int m_lidx(input logic [31:0] pc);
        return int'((pc >> 2) % LHT_N);
    endfunction

    function automatic int m_cidx(input logic [31:0] pc);
        return int'((pc >> 2) % CHS_N);
    endfunction

    function automatic int m_gidx(input logic [31:0] pc, input int ghr);
        return int'((pc >> 2) % GHT_N) ^ ghr;
    endfunction

    function automatic bit m_src(input logic [31:0] pc);
        if (m_busy > 0) return 1'b0;
        return m_chs[m_cidx(pc)] >= THRESH;
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        if (m_busy > 0) return 1'b0;
        if (m_chs[m_cidx(pc)] >= THRESH) return m_glb[m_gidx(pc, m_ghr)] >= THRESH;
        return m_loc[m_lidx(pc)] >= THRESH;
    endfunction

    function automatic void model_reset();
        foreach (m_loc[i]) m_loc[i] = WNT;
        foreach (m_glb[i]) m_glb[i] = WNT;
        foreach (m_chs[i]) m_chs[i] = WNT;
        m_ghr  = 0;
        m_busy = WALK_CYCLES;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // One clock: capture the inputs, let the DUT take the edge, advance model.
    task automatic tick();
        bit          en_c, pv_c, rv_c, rt_c, lp_c, gp_c, rpt_c, pt_c;
        logic [31:0] rpc_c;
        int          rg_c, li, gi, ci, step;
        if (m_busy > 0) begin
            @(posedge clk);
            #1;
            m_busy--;
            return;
        end
        en_c  = pipeline_en;
        pv_c  = pred_valid;
        rv_c  = res_valid;
        rt_c  = res_taken;
        lp_c  = res_local_pred;
        gp_c  = res_global_pred;
        rpt_c = res_pred_taken;
        rpc_c = res_pc;
        rg_c  = int'(res_ghr);
        pt_c  = m_taken(pred_pc);
        @(posedge clk);
        #1;
        if (!en_c) return;
        if (rv_c) begin
            li   = m_lidx(rpc_c);
            gi   = m_gidx(rpc_c, rg_c);
            ci   = m_cidx(rpc_c);
            step = rt_c ? 1 : -1;
            m_loc[li] = sat(m_loc[li] + step);
            m_glb[gi] = sat(m_glb[gi] + step);
            if (gp_c == rt_c && lp_c != rt_c) m_chs[ci] = sat(m_chs[ci] + 1);
            else if (lp_c == rt_c && gp_c != rt_c) m_chs[ci] = sat(m_chs[ci] - 1);
        end
        if (rv_c && rt_c != rpt_c) m_ghr = (rg_c * 2 + int'(rt_c)) % GHT_N;
        else if (pv_c) m_ghr = (m_ghr * 2 + int'(pt_c)) % GHT_N;
    endtask

    task automatic set_idle();
        pipeline_en     = 1'b1;
        pred_valid      = 1'b0;
        pred_pc         = '0;
        res_valid       = 1'b0;
        res_pc          = '0;
        res_taken       = 1'b0;
        res_ghr         = '0;
        res_local_pred  = 1'b0;
        res_global_pred = 1'b0;
        res_pred_taken  = 1'b0;
    endtask

    task automatic rand_inputs(input int en_pct);
        pipeline_en     = ($urandom_range(0, 99) < en_pct);
        pred_valid      = 1'($urandom_range(0, 1));
        pred_pc         = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 15)) << 2);
        res_valid       = 1'($urandom_range(0, 1));
        res_pc          = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 15)) << 2);
        res_taken       = 1'($urandom_range(0, 1));
        res_ghr         = GHR_W'($urandom);
        res_local_pred  = 1'($urandom_range(0, 1));
        res_global_pred = 1'($urandom_range(0, 1));
        res_pred_taken  = 1'($urandom_range(0, 1));
    endtask

    task automatic do_resolve(input logic [31:0] pc, input bit taken, input bit lp,
                              input bit gp, input bit pt, input logic [GHR_W-1:0] ghr);
        set_idle();
        res_valid       = 1'b1;
        res_pc          = pc;
        res_taken       = taken;
        res_local_pred  = lp;
        res_global_pred = gp;
        res_pred_taken  = pt;
        res_ghr         = ghr;
        tick();
        set_idle();
    endtask

    // Called at posedge+1; holds reset across two edges, releases at posedge+1.
    task automatic hold_reset();
        set_idle();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Scenario tasks
    // ------------------------------------------------------------------
    task automatic test_reset();
        int cnt;
        reset_n = 1'b0;
        set_idle();
        #2;
        vectors++;
        if (init_busy !== 1'b1 || pred_ghr !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: busy=%0b ghr=%0h expected busy=1 ghr=00", init_busy, pred_ghr);
        end
        @(posedge clk);
        #1;
        hold_reset();
        cnt = 0;
        while (m_busy > 0) begin
            rand_inputs(50);
            #2;
            if (init_busy === 1'b1) cnt++;
            vectors++;
            if (pred_taken !== 1'b0 || pred_src !== 1'b0 || pred_ghr !== 8'h00) begin
                miscompares++;
                $display("FAIL init_outputs: taken=%0b src=%0b ghr=%0h expected 0 0 00",
                         pred_taken, pred_src, pred_ghr);
            end
            tick();
        end
        set_idle();
        #2;
        vectors++;
        if (cnt !== WALK_CYCLES) begin
            miscompares++;
            $display("FAIL init_length: busy cycles=%0d expected %0d", cnt, WALK_CYCLES);
        end
        vectors++;
        if (init_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL init_done: busy=%0b expected 0", init_busy);
        end
        tick();
    endtask

    task automatic test_init_defaults();
        for (int i = 0; i < 24; i++) begin
            set_idle();
            pred_pc = $urandom;
            #2;
            vectors++;
            if (pred_taken !== 1'b0 || pred_src !== 1'b0) begin
                miscompares++;
                $display("FAIL init_default_lookup: pc=%0h taken=%0b src=%0b expected 0 0",
                         pred_pc, pred_taken, pred_src);
            end
            tick();
        end
    endtask

    task automatic test_local_train();
        // Expected local[16] direction after each resolve at 0x40:
        // T:2 T:3 T:3 T:3 N:2 N:1  -> taken, taken, taken, taken, taken, not
        bit outcomes [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit exp_dir  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        set_idle();
        pred_pc = 32'h40;
        #2;
        vectors++;
        if (pred_taken !== 1'b0 || pred_src !== 1'b0) begin
            miscompares++;
            $display("FAIL local_start: taken=%0b src=%0b expected 0 0", pred_taken, pred_src);
        end
        tick();
        for (int k = 0; k < 6; k++) begin
            do_resolve(32'h40, outcomes[k], 1'b0, 1'b0, 1'b0, 8'h00);
            pred_pc = 32'h40;
            #2;
            vectors++;
            if (pred_taken !== exp_dir[k] || pred_src !== 1'b0) begin
                miscompares++;
                $display("FAIL local_train[%0d]: taken=%0b src=%0b expected %0b 0",
                         k, pred_taken, pred_src, exp_dir[k]);
            end
            tick();
        end
    endtask

    task automatic test_chooser();
        // Chooser[32]: 1 -> 2 -> 3 (global wins), then 3 -> 2 -> 1 (local wins).
        bit gp_seq  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit exp_src [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            do_resolve(32'h80, 1'b1, ~gp_seq[k], gp_seq[k], 1'b1, 8'h00);
            pred_pc = 32'h80;
            #2;
            vectors++;
            if (pred_src !== exp_src[k] || pred_taken !== m_taken(32'h80)) begin
                miscompares++;
                $display("FAIL chooser[%0d]: src=%0b taken=%0b expected %0b %0b",
                         k, pred_src, pred_taken, exp_src[k], m_taken(32'h80));
            end
            tick();
        end
    endtask

    task automatic test_recovery();
        bit pt;
        do_resolve(32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
        #2;
        vectors++;
        if (pred_ghr !== 8'hAA) begin
            miscompares++;
            $display("FAIL recovery_setup: ghr=%0h expected aa", pred_ghr);
        end
        pred_valid      = 1'b1;
        pred_pc         = 32'h0;
        res_valid       = 1'b1;
        res_pc          = 32'h200;
        res_ghr         = 8'h05;
        res_taken       = 1'b1;
        res_pred_taken  = 1'b0;
        vectors++;
        if (pred_taken !== m_taken(32'h0)) begin
            miscompares++;
            $display("FAIL recovery_lookup: taken=%0b expected %0b", pred_taken, m_taken(32'h0));
        end
        tick();
        set_idle();
        #2;
        vectors++;
        if (pred_ghr !== 8'h0B) begin
            miscompares++;
            $display("FAIL recovery_priority: ghr=%0h expected 0b", pred_ghr);
        end
        // Speculative shift alone: history moves left with the prediction.
        pred_valid = 1'b1;
        pred_pc    = $urandom;
        pt         = m_taken(pred_pc);
        tick();
        set_idle();
        #2;
        vectors++;
        if (pred_ghr !== GHR_W'((8'h0B << 1) | pt)) begin
            miscompares++;
            $display("FAIL spec_shift: ghr=%0h expected %0h", pred_ghr, GHR_W'((8'h0B << 1) | pt));
        end
        tick();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            rand_inputs(0);
            pred_valid = 1'b1;
            res_valid  = 1'b1;
            #2;
            vectors++;
            if (pred_ghr !== GHR_W'(m_ghr) || pred_taken !== m_taken(pred_pc)) begin
                miscompares++;
                $display("FAIL stall[%0d]: ghr=%0h taken=%0b expected %0h %0b",
                         i, pred_ghr, pred_taken, m_ghr, m_taken(pred_pc));
            end
            tick();
        end
        for (int i = 0; i < 64; i++) begin
            set_idle();
            pred_pc = 32'(i) << 2;
            #2;
            vectors++;
            if (pred_taken !== m_taken(pred_pc) || pred_src !== m_src(pred_pc)) begin
                miscompares++;
                $display("FAIL stall_sweep: pc=%0h taken=%0b src=%0b expected %0b %0b",
                         pred_pc, pred_taken, pred_src, m_taken(pred_pc), m_src(pred_pc));
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rand_inputs(85);
            #2;
            vectors++;
            if (pred_taken !== m_taken(pred_pc) || pred_src !== m_src(pred_pc) ||
                pred_ghr !== GHR_W'(m_ghr) || init_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL random[%0d]: pc=%0h taken=%0b src=%0b ghr=%0h busy=%0b expected %0b %0b %0h 0",
                         i, pred_pc, pred_taken, pred_src, pred_ghr, init_busy,
                         m_taken(pred_pc), m_src(pred_pc), m_ghr);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_mid_init_reset();
        int cnt;
        hold_reset();
        for (int i = 0; i < 100; i++) begin
            rand_inputs(50);
            tick();
        end
        set_idle();
        reset_n = 1'b0;
        #2;
        vectors++;
        if (init_busy !== 1'b1 || pred_ghr !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_init_reset: busy=%0b ghr=%0h expected 1 00", init_busy, pred_ghr);
        end
        @(posedge clk);
        #1;
        hold_reset();
        cnt = 0;
        while (m_busy > 0) begin
            rand_inputs(50);
            #2;
            if (init_busy === 1'b1) cnt++;
            tick();
        end
        set_idle();
        #2;
        vectors++;
        if (cnt !== WALK_CYCLES || init_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_walk: busy cycles=%0d busy_now=%0b expected %0d 0",
                     cnt, init_busy, WALK_CYCLES);
        end
        tick();
        // Every local and chooser entry is back to weakly-not-taken.
        for (int i = 0; i < 64; i++) begin
            set_idle();
            pred_pc = 32'(i) << 2;
            #2;
            vectors++;
            if (pred_taken !== 1'b0 || pred_src !== 1'b0) begin
                miscompares++;
                $display("FAIL reinit_sweep: pc=%0h taken=%0b src=%0b expected 0 0",
                         pred_pc, pred_taken, pred_src);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and final report
    // ------------------------------------------------------------------
    initial begin
        reset_n = 1'b0;
        set_idle();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_init_defaults();
        test_local_train();
        test_chooser();
        test_recovery();
        test_stall();
        test_random();
        test_mid_init_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
